// File: rtl/arch_pipe_pkg.sv
// Shared MEM->WB payload types: the mem_pl_t beat layout and the skid FSM state encoding.
package arch_pipe_pkg;
  localparam int DATA_W = 32;
  localparam int DEST_W = 4;

  // Field order is the wire layout, MSB first.
  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mem_data;
    logic [DEST_W-1:0] dest;
  } mem_pl_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;
endpackage

// File: rtl/stage_sat_counter.sv
// Saturating event counter: clear beats hold, hold beats increment, sticks at all-ones.
module stage_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                                   cnt_d = '0;
    else if (!hold && inc && (cnt_q != '1))    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/mem_stage_skid_reg.sv
// Two-entry elastic MEM->WB register with freeze and synchronous flush.
// Define STAGE_STATS_EN to build the stall/beat statistics counters; otherwise they read 0.
module mem_stage_skid_reg
  import arch_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  mem_pl_t          in_pl,
  output logic             out_valid,
  input  logic             out_ready,
  output mem_pl_t          out_pl,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] beat_cnt
);
  // The payload type comes from the package; a mismatched override is a build error.
  if (2 + 2*DATA_W + DEST_W != $bits(mem_pl_t)) begin : g_cfg_err
    $error("mem_stage_skid_reg: DATA_W/DEST_W disagree with arch_pipe_pkg");
  end

  skid_state_e state_q, state_d;
  mem_pl_t     main_q, main_d;
  mem_pl_t     skid_q, skid_d;
  logic        push, pop;

  assign in_ready  = (state_q != TWO) & ~freeze & ~flush;
  assign out_valid = (state_q != EMPTY);
  assign out_pl    = main_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready & ~freeze & ~flush;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else if (!freeze) begin
      unique case (state_q)
        EMPTY: if (push) begin
          state_d = ONE;
          main_d  = in_pl;
        end
        // With a simultaneous pop the new beat goes straight to main; skid stays unused.
        ONE: begin
          if (push && pop) main_d = in_pl;
          else if (push) begin
            state_d = TWO;
            skid_d  = in_pl;
          end else if (pop) state_d = EMPTY;
        end
        TWO: if (pop) begin
          state_d = ONE;
          main_d  = skid_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef STAGE_STATS_EN
  stage_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid & ~out_ready),
    .clr  (flush),
    .hold (freeze),
    .cnt  (stall_cnt)
  );

  stage_sat_counter #(.CNT_W(CNT_W)) u_beat_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (pop),
    .clr  (flush),
    .hold (freeze),
    .cnt  (beat_cnt)
  );
`else
  assign stall_cnt = '0;
  assign beat_cnt  = '0;
`endif
endmodule

// File: tb/tb_mem_stage_skid_reg.sv
// Bench for mem_stage_skid_reg: queue-based reference model checked every cycle plus directed scenarios.
module tb_mem_stage_skid_reg;
  import arch_pipe_pkg::*;

  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef STAGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, freeze, flush, in_valid, in_ready, out_valid, out_ready;
  mem_pl_t          in_pl, out_pl;
  logic [CNT_W-1:0] stall_cnt, beat_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  mem_pl_t      mq[$];
  int           m_stall, m_beat;
  bit           m_pop, m_push;
  logic [31:0]  seen[$];

  mem_stage_skid_reg #(.DATA_W(32), .DEST_W(4), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pl     (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pl    (out_pl),
    .stall_cnt (stall_cnt),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  function automatic mem_pl_t mk(input logic [31:0] v);
    mem_pl_t p;
    p.wb_en    = 1'b1;
    p.mem_r_en = v[0];
    p.alu_res  = v;
    p.mem_data = ~v;
    p.dest     = v[3:0];
    return p;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a FIFO of at most two beats plus saturating counters.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_stall = 0;
      m_beat  = 0;
    end else if (flush) begin
      mq.delete();
      m_stall = 0;
      m_beat  = 0;
    end else if (!freeze) begin
      m_pop  = (mq.size() > 0) && out_ready;
      m_push = in_valid && (mq.size() < 2);
      if ((mq.size() > 0) && !out_ready && m_stall < MAXC) m_stall++;
      if (m_pop && m_beat < MAXC) m_beat++;
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(in_pl);
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, mq.size() != 0);
    chk("in_ready", in_ready, (mq.size() < 2) && !freeze && !flush);
    if (mq.size() != 0) chk("out_pl", out_pl, mq[0]);
    chk("stall_cnt", stall_cnt, STATS ? m_stall : 0);
    chk("beat_cnt", beat_cnt, STATS ? m_beat : 0);
    if (!rst && out_valid && out_ready && !freeze && !flush) seen.push_back(out_pl.alu_res);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pl = '0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_beat", beat_cnt, 0);
    cyc(); rst = 1'b0;

    // Async reset while a beat sits in main
    cyc(); in_valid = 1'b1; in_pl = mk(32'h55);
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_beat", beat_cnt, 0);
    cyc(); rst = 1'b0;

    // Streaming 1..8 at full rate
    seen.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc(); in_valid = 1'b1; in_pl = mk(i);
    end
    cyc(); in_valid = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    chk("stream_count", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) chk("stream_order", seen[i], i + 1);
    chk("stream_beat_cnt", beat_cnt, STATS ? 8 : 0);

    // Backpressure: A, B fill both entries
    cyc(); flush = 1'b1;
    cyc(); flush = 1'b0; in_valid = 1'b1; in_pl = mk(32'hA); out_ready = 1'b0;
    cyc(); in_pl = mk(32'hB);
    @(negedge clk);
    chk("bp_in_ready_one", in_ready, 1);
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    chk("bp_two_in_ready", in_ready, 0);
    chk("bp_two_head", out_pl.alu_res, 32'hA);
    chk("bp_stall1", stall_cnt, STATS ? 1 : 0);
    seen.delete();
    cyc(); out_ready = 1'b1;
    @(negedge clk);
    chk("bp_head_a", out_pl.alu_res, 32'hA);
    chk("bp_stall2", stall_cnt, STATS ? 2 : 0);
    cyc();
    @(negedge clk);
    chk("bp_head_b", out_pl.alu_res, 32'hB);
    cyc();
    @(negedge clk);
    chk("bp_drained", out_valid, 0);
    chk("bp_seen_n", seen.size(), 2);
    if (seen.size() == 2) begin
      chk("bp_seen0", seen[0], 32'hA);
      chk("bp_seen1", seen[1], 32'hB);
    end
    chk("bp_beat", beat_cnt, STATS ? 2 : 0);

    // Freeze with C held in main
    cyc(); in_valid = 1'b1; in_pl = mk(32'hC); out_ready = 1'b0;
    cyc(); freeze = 1'b1; in_pl = mk(32'hD); out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("frz_in_ready", in_ready, 0);
      chk("frz_head", out_pl.alu_res, 32'hC);
      chk("frz_stall", stall_cnt, STATS ? 2 : 0);
      chk("frz_beat", beat_cnt, STATS ? 2 : 0);
      cyc();
    end
    freeze = 1'b0; in_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("frz_popped", out_valid, 0);
    chk("frz_beat_after", beat_cnt, STATS ? 3 : 0);

    // Flush from TWO with a beat offered
    in_valid = 1'b1; in_pl = mk(32'hE); out_ready = 1'b0;
    cyc(); in_pl = mk(32'hF);
    cyc(); in_pl = mk(32'h16); flush = 1'b1;
    @(negedge clk);
    chk("fl_in_ready", in_ready, 0);
    chk("fl_valid_before", out_valid, 1);
    cyc(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("fl_valid_after", out_valid, 0);
    chk("fl_in_ready_after", in_ready, 1);
    chk("fl_stall", stall_cnt, 0);
    chk("fl_beat", beat_cnt, 0);
    cyc();
    @(negedge clk);
    chk("fl_no_ghost", out_valid, 0);

    // Stall saturation
    cyc(); in_valid = 1'b1; in_pl = mk(32'h11); out_ready = 1'b0;
    cyc(); in_valid = 1'b0;
    repeat (20) cyc();
    @(negedge clk);
    chk("sat_stall", stall_cnt, STATS ? 15 : 0);
    chk("sat_head", out_pl.alu_res, 32'h11);
    out_ready = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    chk("sat_drained", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
